// File: rtl/motor_bus_scheduler_pkg.sv
// Shared register map, control-word layout and scheduler state encoding for the
// motor bus scheduler and its speed mapper.
package motor_pkg;

    localparam logic [3:0] REG_TOTAL_DUR = 4'h0;
    localparam logic [3:0] REG_HIGH_DUR  = 4'h1;
    localparam logic [3:0] REG_CONTROL   = 4'h2;

    localparam int CTRL_GO         = 0;
    localparam int CTRL_FWD        = 1;
    localparam int CTRL_FAST_DECAY = 2;

    typedef enum logic [2:0] {
        INIT_T0,
        INIT_T1,
        IDLE,
        WR_HIGH,
        WR_CTRL
    } sched_state_t;

    function automatic logic [31:0] ctrl_word(input logic fwd, input logic run);
        logic [31:0] w;
        w                  = '0;
        w[CTRL_GO]         = run;
        w[CTRL_FWD]        = fwd;
        w[CTRL_FAST_DECAY] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/motor_speed_map.sv
// Combinational map from a signed speed command to a PWM high duration
// (magnitude clipped to PERIOD) and a direction bit.
module motor_speed_map #(
    parameter int SPEED_W = 16,
    parameter int PERIOD  = 7000
) (
    input  logic signed [SPEED_W-1:0] speed,
    output logic        [31:0]        high,
    output logic                      forward
);

    logic signed [SPEED_W:0] speed_ext;
    logic        [SPEED_W:0] mag;

    function automatic logic [31:0] sat_period(input logic [SPEED_W:0] m);
        logic [31:0] m32;
        m32 = 32'(m);
        if (m32 > 32'(PERIOD))
            return 32'(PERIOD);
        return m32;
    endfunction

    // One extra bit so negating the most-negative command cannot wrap.
    always_comb begin
        forward   = ~speed[SPEED_W-1];
        speed_ext = $signed({speed[SPEED_W-1], speed});
        mag       = forward ? speed_ext : -speed_ext;
        high      = sat_period(mag);
    end

endmodule

// File: rtl/motor_bus_scheduler.sv
// Arbitrates two motor command requesters onto one Avalon-MM write master.
// Optional macro MOTOR_WDOG_EN adds a per-motor command-timeout stop.
module motor_bus_scheduler
    import motor_pkg::*;
#(
    parameter int PERIOD  = 7000,
    parameter int SPEED_W = 16
`ifdef MOTOR_WDOG_EN
    , parameter int WDOG_CYCLES = 5000000
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [2*SPEED_W-1:0]   req_speed,
    input  logic [1:0]             req_run,
    output logic [1:0]             req_ready,
    output logic                   s_cs,
    output logic [4:0]             s_address,
    output logic                   s_write,
    output logic [31:0]            s_writedata,
    input  logic                   waitrequest,
    output logic                   busy
);

    localparam logic [31:0] PERIOD32 = 32'(PERIOD);

    sched_state_t state, state_nxt;
    logic         cs_nxt;
    logic [4:0]   addr_nxt;
    logic [31:0]  data_nxt;
    logic [1:0]   ready_nxt;
    logic         rr_last, rr_nxt;
    logic         g_q, g_nxt;
    logic         run_q, run_nxt;
    logic         fwd_q, fwd_nxt;
    logic         done, ctrl_done;
    logic         g_sel;
    logic         stop_pending, stop_motor;

    logic signed [SPEED_W-1:0] speed_sel;
    logic        [31:0]        high_map;
    logic                      fwd_map;

    assign done      = s_cs && !waitrequest;
    assign ctrl_done = (state == WR_CTRL) && done;
    assign g_sel     = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
    assign speed_sel = g_sel ? req_speed[2*SPEED_W-1:SPEED_W] : req_speed[SPEED_W-1:0];

    motor_speed_map #(
        .SPEED_W (SPEED_W),
        .PERIOD  (PERIOD)
    ) u_speed_map (
        .speed   (speed_sel),
        .high    (high_map),
        .forward (fwd_map)
    );

`ifdef MOTOR_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] wdog_cnt [2];
    logic [1:0]       last_run;
    logic [1:0]       wdog_hit;

    always_comb begin
        for (int i = 0; i < 2; i++)
            wdog_hit[i] = (wdog_cnt[i] == CNT_W'(WDOG_CYCLES)) && last_run[i];
    end

    assign stop_pending = |wdog_hit;
    assign stop_motor   = ~wdog_hit[0];

    // A CONTROL write with run=0 (the stop itself) restarts the timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt[0] <= '0;
            wdog_cnt[1] <= '0;
            last_run    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ready_nxt[i] || (ctrl_done && g_q == 1'(i) && !run_q))
                    wdog_cnt[i] <= '0;
                else if (wdog_cnt[i] != CNT_W'(WDOG_CYCLES))
                    wdog_cnt[i] <= wdog_cnt[i] + 1'b1;
                if (ctrl_done && g_q == 1'(i))
                    last_run[i] <= run_q;
            end
        end
    end
`else
    assign stop_pending = 1'b0;
    assign stop_motor   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cs_nxt    = s_cs;
        addr_nxt  = s_address;
        data_nxt  = s_writedata;
        ready_nxt = '0;
        rr_nxt    = rr_last;
        g_nxt     = g_q;
        run_nxt   = run_q;
        fwd_nxt   = fwd_q;
        case (state)
            INIT_T0: begin
                if (!s_cs) begin
                    cs_nxt   = 1'b1;
                    addr_nxt = {1'b0, REG_TOTAL_DUR};
                    data_nxt = PERIOD32;
                end else if (done) begin
                    state_nxt = INIT_T1;
                    addr_nxt  = {1'b1, REG_TOTAL_DUR};
                    data_nxt  = PERIOD32;
                end
            end
            INIT_T1: begin
                if (done) begin
                    state_nxt = IDLE;
                    cs_nxt    = 1'b0;
                end
            end
            IDLE: begin
                if (stop_pending) begin
                    state_nxt = WR_HIGH;
                    cs_nxt    = 1'b1;
                    g_nxt     = stop_motor;
                    addr_nxt  = {stop_motor, REG_HIGH_DUR};
                    data_nxt  = '0;
                    fwd_nxt   = 1'b1;
                    run_nxt   = 1'b0;
                end else if (|req_valid) begin
                    state_nxt        = WR_HIGH;
                    cs_nxt           = 1'b1;
                    g_nxt            = g_sel;
                    addr_nxt         = {g_sel, REG_HIGH_DUR};
                    data_nxt         = high_map;
                    fwd_nxt          = fwd_map;
                    run_nxt          = req_run[g_sel];
                    ready_nxt[g_sel] = 1'b1;
                    rr_nxt           = g_sel;
                end
            end
            WR_HIGH: begin
                if (done) begin
                    state_nxt = WR_CTRL;
                    addr_nxt  = {g_q, REG_CONTROL};
                    data_nxt  = ctrl_word(fwd_q, run_q);
                end
            end
            WR_CTRL: begin
                if (done) begin
                    state_nxt = IDLE;
                    cs_nxt    = 1'b0;
                end
            end
            default: state_nxt = INIT_T0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT_T0;
            s_cs        <= 1'b0;
            s_write     <= 1'b0;
            s_address   <= '0;
            s_writedata <= '0;
            req_ready   <= '0;
            busy        <= 1'b1;
            rr_last     <= 1'b1;
        end else begin
            state       <= state_nxt;
            s_cs        <= cs_nxt;
            s_write     <= cs_nxt;
            s_address   <= addr_nxt;
            s_writedata <= data_nxt;
            req_ready   <= ready_nxt;
            busy        <= (state_nxt != IDLE);
            rr_last     <= rr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        g_q   <= g_nxt;
        run_q <= run_nxt;
        fwd_q <= fwd_nxt;
    end

endmodule

// File: tb/tb_motor_bus_scheduler.sv
// Directed bench for motor_bus_scheduler: init writes, command mapping table,
// arbitration, waitrequest stalls, reset abort and (with MOTOR_WDOG_EN) timeout stop.
module tb_motor_bus_scheduler;

    localparam int SPEED_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_speed = '0;
    logic [1:0]  req_run = '0;
    logic [1:0]  req_ready;
    logic        s_cs;
    logic [4:0]  s_address;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        waitrequest = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    motor_bus_scheduler #(
        .PERIOD  (7000),
        .SPEED_W (SPEED_W)
`ifdef MOTOR_WDOG_EN
        , .WDOG_CYCLES (100)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_speed   (req_speed),
        .req_run     (req_run),
        .req_ready   (req_ready),
        .s_cs        (s_cs),
        .s_address   (s_address),
        .s_write     (s_write),
        .s_writedata (s_writedata),
        .waitrequest (waitrequest),
        .busy        (busy)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        int                 m;
        logic signed [15:0] speed;
        logic               run;
        logic [31:0]        high;
        logic [31:0]        ctrl;
    } vec_t;

    wr_t  wlog[$];
    vec_t vecs[8];
    int   cyc = 0;
    int   ready_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_cs && s_write && !waitrequest)
            wlog.push_back('{s_address, s_writedata, cyc});
        if (req_ready != 2'b00)
            ready_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check({name, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_ready(input string name, input logic [1:0] exp);
        int n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(req_ready), 32'(exp));
    endtask

    task automatic check_two(input string name, input logic [4:0] a0, input logic [31:0] d0,
                             input logic [4:0] a1, input logic [31:0] d1);
        check({name, " nwrites"}, 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 2) begin
            check({name, " addr0"}, 32'(wlog[0].addr), 32'(a0));
            check({name, " data0"}, wlog[0].data, d0);
            check({name, " addr1"}, 32'(wlog[1].addr), 32'(a1));
            check({name, " data1"}, wlog[1].data, d1);
        end
    endtask

    initial begin
        vecs[0] = '{0,  16'sd3500,   1'b1, 32'd3500, 32'h3};
        vecs[1] = '{1, -16'sd20000,  1'b1, 32'd7000, 32'h1};
        vecs[2] = '{1, -16'sd32768,  1'b1, 32'd7000, 32'h1};
        vecs[3] = '{0,  16'sd0,      1'b0, 32'd0,    32'h2};
        vecs[4] = '{0,  16'sd7000,   1'b1, 32'd7000, 32'h3};
        vecs[5] = '{1,  16'sd7001,   1'b0, 32'd7000, 32'h2};
        vecs[6] = '{0, -16'sd1,      1'b1, 32'd1,    32'h1};
        vecs[7] = '{1,  16'sd32767,  1'b1, 32'd7000, 32'h3};

        // Reset state
        tick();
        tick();
        check("rst s_cs", 32'(s_cs), 32'd0);
        check("rst s_write", 32'(s_write), 32'd0);
        check("rst s_address", 32'(s_address), 32'd0);
        check("rst s_writedata", s_writedata, 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd1);

        // TOTAL_DUR initialisation
        reset = 1'b0;
        wait_idle("init");
        check_two("init", 5'h00, 32'd7000, 5'h10, 32'd7000);
        check("init ready", 32'(ready_cnt), 32'd0);

        // Command mapping table
        for (int i = 0; i < 8; i++) begin
            logic [1:0] exp_rdy;
            string nm;
            nm = $sformatf("vec%0d", i);
            exp_rdy = 2'b01 << vecs[i].m;
            wlog.delete();
            req_speed[vecs[i].m*SPEED_W +: SPEED_W] = vecs[i].speed;
            req_run[vecs[i].m] = vecs[i].run;
            req_valid = exp_rdy;
            tick();
            check({nm, " ready"}, 32'(req_ready), 32'(exp_rdy));
            check({nm, " cs latency"}, 32'(s_cs), 32'd1);
            req_valid = 2'b00;
            tick();
            check({nm, " ready pulse"}, 32'(req_ready), 32'd0);
            wait_idle(nm);
            check_two(nm, {vecs[i].m[0], 4'h1}, vecs[i].high, {vecs[i].m[0], 4'h2}, vecs[i].ctrl);
        end

        // Both valid with rr_last=1: motor 0 first, one idle cycle, then motor 1
        wlog.delete();
        req_speed = {16'd200, 16'd100};
        req_run = 2'b11;
        req_valid = 2'b11;
        tick();
        check("rr first", 32'(req_ready), 32'h1);
        req_valid = 2'b10;
        tick();
        wait_ready("rr second", 2'b10);
        req_valid = 2'b00;
        wait_idle("rr");
        check("rr nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() >= 4) begin
            check("rr addr0", 32'(wlog[0].addr), 32'h01);
            check("rr data0", wlog[0].data, 32'd100);
            check("rr addr1", 32'(wlog[1].addr), 32'h02);
            check("rr addr2", 32'(wlog[2].addr), 32'h11);
            check("rr data2", wlog[2].data, 32'd200);
            check("rr data3", wlog[3].data, 32'h3);
            check("rr gap", 32'(wlog[2].cyc - wlog[1].cyc), 32'd2);
        end

        // waitrequest stall during WR_HIGH
        wlog.delete();
        req_speed[15:0] = 16'd1234;
        req_run[0] = 1'b1;
        req_valid = 2'b01;
        tick();
        check("wait ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        waitrequest = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("wait hold%0d addr", k), 32'(s_address), 32'h01);
            check($sformatf("wait hold%0d data", k), s_writedata, 32'd1234);
            if (k < 5)
                tick();
        end
        waitrequest = 1'b0;
        wait_idle("wait");
        check_two("wait", 5'h01, 32'd1234, 5'h02, 32'h3);

        // Reset during WR_CTRL aborts and re-runs init
        wlog.delete();
        req_speed[31:16] = 16'd500;
        req_run[1] = 1'b1;
        req_valid = 2'b10;
        tick();
        check("abort ready", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        tick();
        check("abort in ctrl", 32'(s_address), 32'h12);
        waitrequest = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("abort s_cs", 32'(s_cs), 32'd0);
        check("abort s_write", 32'(s_write), 32'd0);
        check("abort busy", 32'(busy), 32'd1);
        reset = 1'b0;
        waitrequest = 1'b0;
        wlog.delete();
        wait_idle("reinit");
        check_two("reinit", 5'h00, 32'd7000, 5'h10, 32'd7000);

`ifdef MOTOR_WDOG_EN
        // Command timeout issues an internal stop on motor 0
        begin
            int rc0;
            int n;
            req_speed[15:0] = 16'd300;
            req_run[0] = 1'b1;
            req_valid = 2'b01;
            tick();
            check("wdog ready", 32'(req_ready), 32'h1);
            req_valid = 2'b00;
            wait_idle("wdog cmd");
            wlog.delete();
            rc0 = ready_cnt;
            n = 0;
            while (!busy && n < 300) begin
                tick();
                n++;
            end
            check("wdog fired", 32'(busy), 32'd1);
            wait_idle("wdog stop");
            check_two("wdog", 5'h01, 32'd0, 5'h02, 32'h2);
            check("wdog no ready", 32'(ready_cnt), 32'(rc0));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
